// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed digit scanner for a BCD-to-seven-segment decoder.
//
// A frame snapshot of DIGITS packed BCD digits is shown one digit at a time.
// Each digit slot lasts PRESCALE clocks. Leading-zero blanking is optional.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   scan enable; low blanks the outputs and freezes the scan
//   digits     in   packed BCD, digit i = digits[4i+3:4i], digit 0 least significant
//   blank_lz   in   leading-zero blanking enable
//   indec      out  BCD code to the decoder, 4'hF = blank
//   sel_n      out  active-low one-hot digit select
//   frame_tick out  one-clock pulse at the start of each frame
module seg_scan_mux #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic                  blank_lz,
    output logic [3:0]            indec,
    output logic [DIGITS-1:0]     sel_n,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_started, w_started_nxt;
    logic [4*DIGITS-1:0] r_snap, w_snap_nxt;
    logic [3:0]          r_indec, w_indec_nxt;
    logic [DIGITS-1:0]   r_sel_n, w_sel_n_nxt;
    logic                r_tick, w_tick_nxt;

    logic [DIGITS-1:0]   w_zero_from;
    logic [3:0]          w_cur_digit;
    logic                w_blank;
    logic                v_acc;

    // w_zero_from[i] is set when snapshot digits i..DIGITS-1 are all zero.
    always_comb begin
        w_zero_from = '0;
        v_acc       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_acc          = v_acc & (r_snap[4*i +: 4] == 4'd0);
            w_zero_from[i] = v_acc;
        end
    end

    assign w_cur_digit = r_snap[{r_idx, 2'b00} +: 4];
    // Digit 0 always shows, so a zero value still displays "0".
    assign w_blank     = blank_lz && (r_idx != '0) && w_zero_from[r_idx];

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_started_nxt = r_started;
        w_snap_nxt    = r_snap;
        w_tick_nxt    = 1'b0;
        w_sel_n_nxt   = '1;
        w_indec_nxt   = 4'hF;

        if (en) begin
            if (!r_started) begin
                w_snap_nxt    = digits;
                w_started_nxt = 1'b1;
                w_tick_nxt    = 1'b1;
            end else begin
                // Outputs reflect the pre-edge idx/snap, so they lag by one clock.
                w_sel_n_nxt = ~(DIGITS'(1) << r_idx);
                w_indec_nxt = w_blank ? 4'hF : w_cur_digit;
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_MAX) begin
                        // Re-snapshot only at the frame boundary so the display never tears.
                        w_idx_nxt  = '0;
                        w_snap_nxt = digits;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
            r_snap    <= '0;
            r_sel_n   <= '1;
            r_indec   <= 4'hF;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_started <= w_started_nxt;
            r_snap    <= w_snap_nxt;
            r_sel_n   <= w_sel_n_nxt;
            r_indec   <= w_indec_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign indec      = r_indec;
    assign sel_n      = r_sel_n;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4: one instance at PRESCALE=3 and one at
// PRESCALE=1, sharing all inputs. Observed values are packed as {frame_tick, sel_n, indec}.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic        blank_lz;

    logic [3:0]  indec_a, indec_b;
    logic [3:0]  sel_n_a, sel_n_b;
    logic        tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .PRESCALE(3)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits    (digits),
        .blank_lz  (blank_lz),
        .indec     (indec_a),
        .sel_n     (sel_n_a),
        .frame_tick(tick_a)
    );

    seg_scan_mux #(.DIGITS(4), .PRESCALE(1)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits    (digits),
        .blank_lz  (blank_lz),
        .indec     (indec_b),
        .sel_n     (sel_n_b),
        .frame_tick(tick_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed tick/sel_n/indec=%b/%b/%h expected %b/%b/%h", tag,
                   obs[8], obs[7:4], obs[3:0], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic check_a(input string tag, input logic t, input logic [3:0] s,
                           input logic [3:0] d);
        check(tag, {tick_a, sel_n_a, indec_a}, {t, s, d});
    endtask

    task automatic check_b(input string tag, input logic t, input logic [3:0] s,
                           input logic [3:0] d);
        check(tag, {tick_b, sel_n_b, indec_b}, {t, s, d});
    endtask

    // One full PRESCALE=3 frame starting just after a wrap edge. e0..e3 are the expected
    // indec codes per digit; digits is changed to chg_val after step chg_at (0 = never).
    task automatic run_frame(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3, input int chg_at,
                             input logic [15:0] chg_val);
        logic [3:0] exp_d [4];
        logic [3:0] sel_tab [4];
        exp_d   = '{e0, e1, e2, e3};
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 1; k <= 12; k++) begin
            step();
            check_a(tag, (k == 12), sel_tab[(k-1)/3], exp_d[(k-1)/3]);
            if (k == chg_at) digits = chg_val;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        digits   = 16'h4321;
        blank_lz = 1'b0;
        step();
        step();
        check_a("reset_a", 1'b0, 4'b1111, 4'hF);
        check_b("reset_b", 1'b0, 4'b1111, 4'hF);

        // Enabled but still in reset: reset wins.
        en = 1'b1;
        step();
        check_a("reset_wins", 1'b0, 4'b1111, 4'hF);

        rst_n = 1'b1;
        step();
        check_a("first_snap", 1'b1, 4'b1111, 4'hF);
        run_frame("frame_4321", 4'h1, 4'h2, 4'h3, 4'h4, 0, 16'h0);

        // blank_lz has no visible effect on 4321; 0070 is loaded at this frame's wrap.
        digits   = 16'h0070;
        blank_lz = 1'b1;
        run_frame("frame_4321_lz", 4'h1, 4'h2, 4'h3, 4'h4, 0, 16'h0);
        run_frame("lz_0070", 4'h0, 4'h7, 4'hF, 4'hF, 0, 16'h0);

        blank_lz = 1'b0;
        digits   = 16'h0000;
        run_frame("nolz_0070", 4'h0, 4'h7, 4'h0, 4'h0, 0, 16'h0);

        blank_lz = 1'b1;
        digits   = 16'h1111;
        run_frame("lz_0000", 4'h0, 4'hF, 4'hF, 4'hF, 0, 16'h0);

        // digits changes while idx=1; the current frame must keep showing 1s.
        run_frame("no_tear", 4'h1, 4'h1, 4'h1, 4'h1, 4, 16'h9999);

        // Scan to idx=2, cnt=1, then freeze for 5 clocks.
        for (int k = 1; k <= 7; k++) step();
        check_a("pre_freeze", 1'b0, 4'b1011, 4'h9);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_a("frozen", 1'b0, 4'b1111, 4'hF);
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_a("resume_d2", 1'b0, 4'b1011, 4'h9);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            check_a("resume_d3", (k == 3), 4'b0111, 4'h9);
        end

        // Reset in the middle of a frame, then restart with a fresh snapshot.
        for (int k = 1; k <= 4; k++) step();
        check_a("mid_frame", 1'b0, 4'b1101, 4'h9);
        digits = 16'h5678;
        rst_n  = 1'b0;
        step();
        check_a("mid_reset_a", 1'b0, 4'b1111, 4'hF);
        check_b("mid_reset_b", 1'b0, 4'b1111, 4'hF);
        rst_n = 1'b1;
        step();
        check_a("restart_snap_a", 1'b1, 4'b1111, 4'hF);
        check_b("restart_snap_b", 1'b1, 4'b1111, 4'hF);

        // PRESCALE=1 instance: new digit every clock, tick every 4 clocks.
        begin
            logic [3:0] exp_b [4];
            logic [3:0] sel_b [4];
            exp_b = '{4'h8, 4'h7, 4'h6, 4'h5};
            sel_b = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
            for (int k = 1; k <= 8; k++) begin
                step();
                check_b("p1_scan", (k % 4 == 0), sel_b[(k-1)%4], exp_b[(k-1)%4]);
                if (k <= 3) check_a("restart_d0", 1'b0, 4'b1110, 4'h8);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
